// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces three active-low board keys,
// emits one-cycle press pulses and keeps a start/stop run flag.
// Optional feature macro: BUTTON_CONDITIONER_AUTOREPEAT_EN adds auto-repeat
// press pulses on bit2 (change key) while it is held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic       clk100_i,
  input  logic       rst_i,
  input  logic [2:0] keys_n_i,
  output logic [2:0] level_o,
  output logic [2:0] press_o,
  output logic       start_stop_reg_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value seen on the cycle before it would reach DEBOUNCE_CYCLES.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: cycle parameters must be >= 1");
  end

  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      s;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [2:0]      level_q, level_d;
  logic [2:0]      press_q, press_d;
  logic            ss_q, ss_d;
  logic            rep_pulse;

  // Two-flop synchronizer; reset parks it at the released (high) level.
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= keys_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce: count consecutive disagreeing samples, flip level on the last one.
  always_comb begin
    s       = ~sync2_q;
    level_d = level_q;
    for (int k = 0; k < 3; k++) begin
      db_cnt_d[k] = '0;
      if (s[k] != level_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          level_d[k] = s[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rep_q, rep_d;

  // Hold timer for bit2: first pulse after LONG_CYCLES, then every REPEAT_CYCLES;
  // only counts while the key stays accepted, so a release mid-count emits nothing.
  always_comb begin
    hold_cnt_d = '0;
    rep_d      = 1'b0;
    rep_pulse  = 1'b0;
    if (level_q[2] && level_d[2]) begin
      if ((!rep_q && hold_cnt_q == LONG_LAST) || (rep_q && hold_cnt_q == REP_LAST)) begin
        rep_pulse = 1'b1;
        rep_d     = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        rep_d      = rep_q;
      end
    end
  end

  // Hold timer state.
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      hold_cnt_q <= '0;
      rep_q      <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      rep_q      <= rep_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  // Press pulses on accepted 0->1 edges (plus repeats on bit2); run flag follows press_o[0].
  always_comb begin
    press_d    = level_d & ~level_q;
    press_d[2] = press_d[2] | rep_pulse;
    ss_d       = ss_q ^ press_q[0];
  end

  // Debounce counters and registered outputs.
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
      level_q <= '0;
      press_q <= '0;
      ss_q    <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
      level_q <= level_d;
      press_q <= press_d;
      ss_q    <= ss_d;
    end
  end

  assign level_o          = level_q;
  assign press_o          = press_q;
  assign start_stop_reg_o = ss_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 1000000 and SHALL set the number of consecutive stable samples needed to accept a new key level; legal range is >= 1.
REQ-003 Parameter LONG_CYCLES SHALL default to 50000000 and SHALL set the hold time, after an accepted press, before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_CYCLES SHALL default to 20000000 and SHALL set the period between subsequent auto-repeat pulses.
REQ-005 Ports SHALL be:
- clk100_i  input  1  system clock, 100 MHz
- rst_i  input  1  asynchronous reset, active-high
- keys_n_i  input  3  raw board keys, active-low, asynchronous to clk100_i; bit0 start/stop, bit1 set, bit2 change
- level_o  output  3  debounced key level, 1 = pressed
- press_o  output  3  one-cycle pulse per accepted press, plus auto-repeat pulses on bit2
- start_stop_reg_o  output  1  run flag, toggled by each start/stop press

Function
REQ-006 Each keys_n_i bit SHALL pass through a 2-flop synchronizer and then be inverted, giving the sampled pressed level s[k].
REQ-007 Each key SHALL have an independent debounce counter sized to hold DEBOUNCE_CYCLES.
- Any cycle where s[k] equals level_o[k] clears the counter to 0.
- Each cycle where s[k] differs from level_o[k] increments the counter.
- level_o[k] takes s[k], and the counter clears, on the cycle the counter would reach DEBOUNCE_CYCLES.
REQ-008 Latency SHALL be fixed: a raw change held steady reaches level_o exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it.
REQ-009 press_o[k] SHALL be high for exactly the one cycle in which level_o[k] goes 0->1; release (1->0) SHALL produce no pulse.
REQ-010 start_stop_reg_o SHALL toggle on the clock edge after press_o[0] is high.
REQ-011 Keys SHALL be fully independent: simultaneous presses produce same-cycle pulses on each bit, with no priority or masking.
REQ-012 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no change on level_o or press_o, and it restarts the count.
REQ-013 All outputs SHALL be registered; no output SHALL depend combinationally on keys_n_i.

Reset
REQ-014 While rst_i is high, the following SHALL be forced to 0: level_o, press_o, start_stop_reg_o, all debounce and hold counters.
REQ-015 While rst_i is high, the synchronizer flops SHALL be forced to 1 (released state).
REQ-016 Reset asserted mid-debounce or mid-hold SHALL discard progress; after release, a held key needs a full DEBOUNCE_CYCLES+2 to be accepted and then emits a fresh press pulse.
REQ-017 Reset deassertion SHALL take effect on the next clk100_i edge; no output pulses on the deassertion edge.

Configuration
REQ-018 Macro BUTTON_CONDITIONER_AUTOREPEAT_EN SHALL enable auto-repeat on bit2 (change).
- A hold counter starts at the accepted press.
- An extra press_o[2] pulse fires LONG_CYCLES cycles after the press pulse, then every REPEAT_CYCLES cycles while level_o[2] stays 1.
- The hold counter clears when level_o[2] falls.
- A release mid-count emits no pulse.
REQ-019 Without BUTTON_CONDITIONER_AUTOREPEAT_EN:
- No hold logic is built.
- press_o[2] pulses only per REQ-009.
- LONG_CYCLES and REPEAT_CYCLES are ignored.
- Ports are unchanged.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8)
REQ-020 Clean press: keys_n_i[1]=0 for 12 cycles -> level_o[1] rises at edge 6 after first sampling edge; single press_o[1] pulse that cycle; level_o[1] falls 6 edges after release.
REQ-021 Bounce: keys_n_i[0] low 3, high 1, low 10 cycles -> exactly one press_o[0] pulse, 6 edges after the start of the final low; start_stop_reg_o 0->1 on the following edge.
REQ-022 Toggle: two separated clean presses of bit0 -> start_stop_reg_o 0->1->0, exactly one toggle per press.
REQ-023 Reset mid-debounce: key1 low, rst_i pulsed at edge 3 while key stays low -> all outputs 0 during reset; level_o[1] rises 6 edges after reset release with one press_o[1] pulse.
REQ-024 Auto-repeat: key2 held 50 cycles.
- With macro: press_o[2] pulses at offsets 0, 20, 28, 36, 44 from level_o[2] rise.
- Without macro: only offset 0.
- No pulse after release.
REQ-025 Simultaneous: keys 0 and 2 pressed on the same edge -> press_o[0] and press_o[2] high in the same cycle; press_o[1] stays 0.
